// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encodings and address helper for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 10'd0;
  // Encoding chosen to fall into the decoder's default (no-op) case.
  localparam logic [INSTR_W-1:0] NOP = 16'hFFFF;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + 10'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: ROM port toward the instruction memory and the decoder handshake.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [ADDR_W-1:0]  rRomAddr;
  logic [INSTR_W-1:0] wRomData;
  logic [INSTR_W-1:0] rInstruction;
  logic               rValid;
  logic [ADDR_W-1:0]  rPC;
  logic               wStall;
  logic               wBranch_taken;
  logic               wJumpTaken;
  logic [ADDR_W-1:0]  wBranch_dir;

  modport master (
    output rRomAddr, rInstruction, rValid, rPC,
    input  wRomData, wStall, wBranch_taken, wJumpTaken, wBranch_dir
  );

  modport slave (
    input  rRomAddr, rInstruction, rValid, rPC,
    output wRomData, wStall, wBranch_taken, wJumpTaken, wBranch_dir
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a synchronous ROM, presents instructions to the decoder,
// and handles stalls (hold register) and branch/jump redirects (one flush bubble).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         Clock,
  input  logic         Reset,
  fetch_unit_if.master bus
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic               valid;
  logic               redirect;

  assign valid    = (state_q == S_RUN) || (state_q == S_STALL);
  assign redirect = (bus.wBranch_taken | bus.wJumpTaken) & valid & ~bus.wStall;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    case (state_q)
      S_INIT: begin
        pc_d       = RESET_PC;
        rom_addr_d = addr_inc(RESET_PC);
        state_d    = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (bus.wStall) begin
          // Only the first stalled cycle captures; the ROM already shows the next word.
          if (state_q == S_RUN) begin
            hold_d = bus.wRomData;
          end
          state_d = S_STALL;
        end else if (redirect) begin
          rom_addr_d = bus.wBranch_dir;
          state_d    = S_FLUSH;
        end else begin
          pc_d       = rom_addr_q;
          rom_addr_d = addr_inc(rom_addr_q);
          state_d    = S_RUN;
        end
      end
      S_FLUSH: begin
        pc_d       = rom_addr_q;
        rom_addr_d = addr_inc(rom_addr_q);
        state_d    = S_RUN;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_comb begin
    bus.rRomAddr = rom_addr_q;
    bus.rPC      = pc_q;
    bus.rValid   = valid;
    case (state_q)
      S_RUN:   bus.rInstruction = bus.wRomData;
      S_STALL: bus.rInstruction = hold_q;
      default: bus.rInstruction = NOP;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_INIT;
      rom_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      hold_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 10'd0, address of the first instruction fetched after reset.
REQ-002 Clock  input  1  single system clock, rising edge; one clock domain only.
REQ-003 Reset  input  1  reset is synchronous and active-high.
REQ-004 wRomData  input  16  instruction ROM read data.
REQ-005 wStall  input  1  presented instruction not consumed this cycle.
REQ-006 wBranch_taken  input  1  decoder conditional-branch redirect.
REQ-007 wJumpTaken  input  1  decoder unconditional-jump redirect.
REQ-008 wBranch_dir  input  10  absolute redirect target, zero-extended.
REQ-009 rRomAddr  output  10  instruction ROM read address.
REQ-010 rInstruction  output  16  instruction word presented to the decoder.
REQ-011 rValid  output  1  rInstruction is a real program instruction.
REQ-012 rPC  output  10  address of the instruction on rInstruction.

Function
REQ-013 The ROM SHALL be treated as synchronous: data for rRomAddr sampled at edge k SHALL appear on wRomData during cycle k+1.
REQ-014 The FSM SHALL have exactly four states: INIT, RUN, STALL, FLUSH.
REQ-015 INIT: rValid=0, rInstruction=`NOP, rRomAddr=RESET_PC; next edge goes to RUN with rRomAddr<=RESET_PC+1, rPC<=RESET_PC.
REQ-016 RUN: rValid=1, rInstruction=wRomData combinationally, rPC holds the address fetched on the previous edge.
REQ-017 RUN with wStall=1: capture wRomData into a hold register, hold rRomAddr and rPC, go to STALL.
REQ-018 RUN with wStall=0 and a redirect: rRomAddr<=wBranch_dir, go to FLUSH.
REQ-019 RUN with wStall=0 and no redirect: rPC<=rRomAddr, rRomAddr<=rRomAddr+1, stay in RUN.
REQ-020 STALL: rValid=1, rInstruction=hold register, rPC and rRomAddr unchanged.
REQ-021 STALL exit: wStall=1 stays in STALL; wStall=0 with a redirect behaves as REQ-018; wStall=0 without a redirect behaves as REQ-019 and returns to RUN with no bubble.
REQ-022 FLUSH (one cycle): rValid=0, rInstruction=`NOP; next edge sets rPC<=rRomAddr, rRomAddr<=rRomAddr+1, and goes to RUN.
REQ-023 A redirect SHALL be (wBranch_taken | wJumpTaken) & rValid & ~wStall.
REQ-024 Both redirect inputs high together SHALL produce a single redirect to wBranch_dir.
REQ-025 Redirect and wStall SHALL be ignored in INIT and FLUSH.
REQ-026 Address arithmetic SHALL be 10-bit modulo: 10'h3FF+1 = 10'h000.
REQ-027 A redirect to the current rPC (self-loop) SHALL be legal and costs one bubble.
REQ-028 Every taken redirect SHALL cost exactly one invalid cycle.
REQ-029 A stall SHALL cost zero extra cycles beyond its duration.

Reset
REQ-030 While Reset=1 at an edge, the next state SHALL be: state=INIT, rRomAddr=RESET_PC, rPC=RESET_PC, rValid=0, rInstruction=`NOP, hold register=16'h0000.
REQ-031 Reset SHALL override any state, including STALL or FLUSH, and any simultaneous redirect or stall.
REQ-032 Fetch SHALL restart from RESET_PC per REQ-015 after reset.

Structure
REQ-033 `NOP (an encoding that decodes to the decoder default case) and the FSM state encodings SHALL live in definitions.v.
REQ-034 The block SHALL be a single module; no sub-module is natural (the incrementer and hold register stay inline).
REQ-035 rInstruction/rValid SHALL connect directly to the decoder's wInstruction, and the decoder's branch/jump outputs SHALL connect directly to the redirect inputs.

Verification
REQ-036 Reset release, ROM mem[i]=16'hA000+i -> cycle 1: rValid=0, rRomAddr=0; cycle 2: rPC=0, rInstruction=16'hA000; then rPC increments by 1 per cycle.
REQ-037 wJumpTaken=1, wBranch_dir=10'h040 at rPC=5 -> next cycle rValid=0 and `NOP; following cycle rPC=10'h040, rInstruction=mem[0x40].
REQ-038 wStall high for 3 cycles at rPC=7 -> rPC=7, rInstruction=mem[7], rRomAddr=8 for 4 cycles; next cycle rPC=8 with no bubble.
REQ-039 wBranch_taken=1 held while stalled at rPC=9, wBranch_dir=10'h010 -> no redirect until wStall drops; then one bubble; then rPC=10'h010.
REQ-040 RESET_PC=10'h3FE -> rPC sequence 3FE, 3FF, 000, 001.
REQ-041 Reset asserted during FLUSH and during STALL -> next cycle INIT outputs with rPC=RESET_PC; redirect ignored.
